// File: rtl/kamikaze_fetch.sv
// Fetch/realign stage: owns the fetch PC, reads words over a single-outstanding req/ack bus
// and hands instructions to the decoder. Define KAMIKAZE_RVC_EN to enable RVC realignment.
module kamikaze_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic        is_compressed_instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

`ifdef KAMIKAZE_RVC_EN
  localparam logic [31:0] PcMask = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PcMask = 32'hFFFF_FFFC;
`endif
  localparam logic [31:0] ResetBufPc = RESET_PC & PcMask;
  localparam logic [31:0] ResetFetch = RESET_PC & 32'hFFFF_FFFC;
  localparam logic        ResetSkip  = ResetBufPc[1];

  state_e      state_q, state_d;
  logic [47:0] buf_q, buf_d, buf_sh;
  logic [1:0]  cnt_q, cnt_d, cnt_sh, n_use, n_app;
  logic [31:0] buf_pc_q, buf_pc_d, fetch_q, fetch_d, drop_addr_q, drop_addr_d;
  logic        skip_q, skip_d;
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic        comp_q, comp_d, valid_q, valid_d;
  logic [31:0] tgt, app;
  logic        is_c, rdy, load, ack_ok, room, refill;

  assign tgt = redirect_pc_i & PcMask;

  // Buffer realignment and output stage next state
  always_comb begin
`ifdef KAMIKAZE_RVC_EN
    is_c = buf_q[1:0] != 2'b11;
    rdy  = is_c ? (cnt_q != 2'd0) : (cnt_q >= 2'd2);
`else
    is_c = 1'b0;
    rdy  = cnt_q >= 2'd2;
`endif
    load   = rdy && (!valid_q || instr_ready_i) && !redirect_i;
    n_use  = !load ? 2'd0 : (is_c ? 2'd1 : 2'd2);
    ack_ok = (state_q == StReq) && imem_ack_i && !redirect_i;
    buf_sh = buf_q >> {n_use, 4'b0000};
    cnt_sh = cnt_q - n_use;
    app    = skip_q ? {16'h0000, imem_rdata_i[31:16]} : imem_rdata_i;
    n_app  = skip_q ? 2'd1 : 2'd2;

    buf_d       = buf_sh;
    cnt_d       = cnt_sh;
    buf_pc_d    = buf_pc_q;
    fetch_d     = fetch_q;
    skip_d      = skip_q;
    drop_addr_d = drop_addr_q;
    if (load) buf_pc_d = buf_pc_q + (is_c ? 32'd2 : 32'd4);
    if (ack_ok) begin
      // Slots at or above the count are always zero, so OR-ing in the new halfwords is safe.
      buf_d   = buf_sh | ({16'h0000, app} << {cnt_sh, 4'b0000});
      cnt_d   = cnt_sh + n_app;
      fetch_d = fetch_q + 32'd4;
      skip_d  = 1'b0;
    end
    if (redirect_i) begin
      buf_d    = '0;
      cnt_d    = 2'd0;
      buf_pc_d = tgt;
      fetch_d  = tgt & 32'hFFFF_FFFC;
      skip_d   = tgt[1];
      if (state_q == StReq) drop_addr_d = fetch_q;
    end

    instr_d = instr_q;
    pc_d    = pc_q;
    comp_d  = comp_q;
    valid_d = valid_q;
    if (redirect_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = is_c ? {16'h0000, buf_q[15:0]} : buf_q[31:0];
      pc_d    = buf_pc_q;
      comp_d  = is_c;
    end else if (instr_ready_i) begin
      valid_d = 1'b0;
    end

`ifdef KAMIKAZE_RVC_EN
    room   = cnt_q <= 2'd1;
    refill = cnt_d <= 2'd1;
`else
    room   = (cnt_q == 2'd0) || (n_use != 2'd0);
    refill = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!redirect_i && room) state_d = StReq;
      StReq: begin
        if (redirect_i)      state_d = StDrop;
        else if (imem_ack_i) state_d = refill ? StReq : StIdle;
      end
      StDrop:  if (imem_ack_i && !redirect_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // The dropped request keeps its original address until its ack returns
  always_comb begin
    imem_req_o  = state_q != StIdle;
    imem_addr_o = (state_q == StDrop) ? drop_addr_q : fetch_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_q       <= '0;
      cnt_q       <= 2'd0;
      buf_pc_q    <= ResetBufPc;
      fetch_q     <= ResetFetch;
      drop_addr_q <= ResetFetch;
      skip_q      <= ResetSkip;
      instr_q     <= '0;
      pc_q        <= '0;
      comp_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      buf_pc_q    <= buf_pc_d;
      fetch_q     <= fetch_d;
      drop_addr_q <= drop_addr_d;
      skip_q      <= skip_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      comp_q      <= comp_d;
      valid_q     <= valid_d;
    end
  end

  assign instr_o               = instr_q;
  assign pc_o                  = pc_q;
  assign is_compressed_instr_o = comp_q;
  assign instr_valid_o         = valid_q;

endmodule

// File: tb/tb_kamikaze_fetch.sv
// Directed bench for kamikaze_fetch: memory responder with programmable latency, transfer
// monitor, and hand-computed expected instruction streams (RVC or word-only build).
module tb_kamikaze_fetch;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] instr_o;
  logic        is_compressed_instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;

  kamikaze_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .imem_req_o            (imem_req_o),
    .imem_addr_o           (imem_addr_o),
    .imem_ack_i            (imem_ack_i),
    .imem_rdata_i          (imem_rdata_i),
    .redirect_i            (redirect_i),
    .redirect_pc_i         (redirect_pc_i),
    .instr_o               (instr_o),
    .is_compressed_instr_o (is_compressed_instr_o),
    .pc_o                  (pc_o),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [256];
  int          lat = 1;
  int          wait_c = 0;
  bit          force_ack = 1'b0;
  logic [31:0] aq[$];
  logic [31:0] xi[$];
  logic [31:0] xp[$];
  logic        xc[$];
  logic [31:0] ei[$];
  logic [31:0] ep[$];
  logic        ec[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory: acks after lat cycles of request; records the address of every normal ack
  always @(negedge clk_i) begin
    imem_ack_i = 1'b0;
    if (force_ack) begin
      imem_ack_i   = 1'b1;
      imem_rdata_i = 32'hDEAD_BEEF;
      wait_c       = 0;
    end else if (imem_req_o) begin
      wait_c++;
      if (wait_c >= lat) begin
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem[imem_addr_o[9:2]];
        aq.push_back(imem_addr_o);
        wait_c       = 0;
      end
    end else begin
      wait_c = 0;
    end
  end

  always @(negedge clk_i) begin
    if (instr_valid_o && instr_ready_i) begin
      xi.push_back(instr_o);
      xp.push_back(pc_o);
      xc.push_back(is_compressed_instr_o);
    end
  end

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic clear_q();
    aq.delete();
    xi.delete();
    xp.delete();
    xc.delete();
  endtask

  task automatic start(input int l, input logic rdy);
    rst_i         = 1'b0;
    redirect_i    = 1'b0;
    force_ack     = 1'b0;
    lat           = l;
    instr_ready_i = rdy;
    repeat (2) @(posedge clk_i);
    #1;
    clear_q();
    rst_i = 1'b1;
  endtask

  task automatic exp_x(input logic [31:0] i, input logic [31:0] p, input logic c);
    ei.push_back(i);
    ep.push_back(p);
    ec.push_back(c);
  endtask

  task automatic check_xfers(input string tag);
    int cyc = 0;
    while (xi.size() < ei.size() && cyc < 300) begin
      @(posedge clk_i);
      cyc++;
    end
    #1;
    check_eq({tag, "_count"}, 32'(xi.size()), 32'(ei.size()));
    for (int i = 0; i < ei.size(); i++) begin
      if (i < xi.size()) begin
        check_eq($sformatf("%s_instr%0d", tag, i), xi[i], ei[i]);
        check_eq($sformatf("%s_pc%0d", tag, i), xp[i], ep[i]);
        check_eq($sformatf("%s_comp%0d", tag, i), 32'(xc[i]), 32'(ec[i]));
      end
    end
    ei.delete();
    ep.delete();
    ec.delete();
  endtask

  task automatic wait_req(input string tag);
    int cyc = 0;
    while (!imem_req_o && cyc < 20) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    check_eq({tag, "_req_seen"}, 32'(imem_req_o), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_req"}, 32'(imem_req_o), 32'd0);
    check_eq({tag, "_addr"}, imem_addr_o, 32'h0);
    check_eq({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    check_eq({tag, "_instr"}, instr_o, 32'h0);
    check_eq({tag, "_pc"}, pc_o, 32'h0);
    check_eq({tag, "_comp"}, 32'(is_compressed_instr_o), 32'd0);
  endtask

  initial begin
    fill_nop();
    @(posedge clk_i);
    #1;
    check_reset_outs("reset");

    // Two plain 32-bit words
    fill_nop();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    start(1, 1'b1);
    exp_x(32'h0050_0093, 32'h0, 1'b0);
    exp_x(32'h00A0_0113, 32'h4, 1'b0);
    check_xfers("basic");
    check_eq("basic_addr0", aq[0], 32'h0);
    check_eq("basic_addr1", aq[1], 32'h4);

    // Two compressed instructions in one word
    fill_nop();
    mem[0] = 32'h0085_4501;
    start(1, 1'b1);
`ifdef KAMIKAZE_RVC_EN
    exp_x(32'h0000_4501, 32'h0, 1'b1);
    exp_x(32'h0000_0085, 32'h2, 1'b1);
`else
    exp_x(32'h0085_4501, 32'h0, 1'b0);
`endif
    check_xfers("pair");

    // 32-bit instruction straddling a word boundary
    fill_nop();
    mem[0] = 32'h0093_4501;
    mem[1] = 32'h0001_0050;
    start(1, 1'b1);
`ifdef KAMIKAZE_RVC_EN
    exp_x(32'h0000_4501, 32'h0, 1'b1);
    exp_x(32'h0050_0093, 32'h2, 1'b0);
    exp_x(32'h0000_0001, 32'h6, 1'b1);
`else
    exp_x(32'h0093_4501, 32'h0, 1'b0);
    exp_x(32'h0001_0050, 32'h4, 1'b0);
`endif
    check_xfers("straddle");

    // Redirect to 0x102 while a slow request is outstanding
    fill_nop();
    mem[0]  = 32'h0050_0093;
    mem[64] = 32'h0001_4501;
    mem[65] = 32'h00A0_0113;
    start(3, 1'b1);
    wait_req("redir");
    clear_q();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    @(posedge clk_i);
    #1;
    redirect_i = 1'b0;
`ifdef KAMIKAZE_RVC_EN
    exp_x(32'h0000_0001, 32'h102, 1'b1);
`else
    exp_x(32'h0001_4501, 32'h100, 1'b0);
`endif
    exp_x(32'h00A0_0113, 32'h104, 1'b0);
    check_xfers("redir");
    check_eq("redir_drop_addr", aq[0], 32'h0);
    check_eq("redir_new_addr", aq[1], 32'h100);

    // Decoder stall: output held, fetching stops, then drains without loss
    for (int k = 0; k < 256; k++) mem[k] = 32'h0000_0013 | (32'(k) << 20);
    start(1, 1'b0);
    repeat (12) @(posedge clk_i);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      #1;
      check_eq($sformatf("stall_instr_c%0d", c), instr_o, 32'h0000_0013);
      check_eq($sformatf("stall_pc_c%0d", c), pc_o, 32'h0);
      check_eq($sformatf("stall_valid_c%0d", c), 32'(instr_valid_o), 32'd1);
    end
    check_eq("stall_req_low", 32'(imem_req_o), 32'd0);
    instr_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) exp_x(32'h0000_0013 | (32'(k) << 20), 32'(4 * k), 1'b0);
    check_xfers("stall");

    // Reset in the middle of a request; an ack during and just after reset is ignored
    fill_nop();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    start(1, 1'b1);
    begin
      int cyc = 0;
      while (!(xi.size() >= 1 && imem_req_o) && cyc < 50) begin
        @(posedge clk_i);
        #1;
        cyc++;
      end
      check_eq("midrst_busy_seen", 32'(imem_req_o), 32'd1);
    end
    rst_i = 1'b0;
    #1;
    check_reset_outs("midrst");
    force_ack = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outs("midrst_ack");
    clear_q();
    rst_i     = 1'b1;
    force_ack = 1'b0;
    exp_x(32'h0050_0093, 32'h0, 1'b0);
    exp_x(32'h00A0_0113, 32'h4, 1'b0);
    check_xfers("midrst");
    check_eq("midrst_addr0", aq[0], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
